// File: rtl/nmos_clk_gen.sv
// nmos_clk_gen: two-phase non-overlapping clock enables (phi1/phi2) for NMOS DFF cells,
// with free-run, single-step and completed-cycle counting.
module nmos_clk_gen #(
    parameter int HI_CYC  = 4,
    parameter int GAP_CYC = 1,
    parameter int CNT_W   = 32
) (
    input  logic             main_clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    output logic             phi1,
    output logic             phi2,
    output logic             phi1_start,
    output logic             phi2_start,
    output logic             busy,
    output logic [CNT_W-1:0] cyc_cnt
);
    typedef enum logic [2:0] {IDLE, P1, G1, P2, G2} state_t;

    localparam logic [7:0] HI_LAST  = 8'(HI_CYC - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [7:0]       dwell_q, dwell_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic             phi1_q, phi1_d;
    logic             phi2_q, phi2_d;
    logic             phi1_start_q, phi1_start_d;
    logic             phi2_start_q, phi2_start_d;
    logic             busy_q, busy_d;
    logic             expired;

    always_comb begin
        expired   = (state_q == P1 || state_q == P2) ? (dwell_q == HI_LAST) : (dwell_q == GAP_LAST);
        state_d   = state_q;
        dwell_d   = dwell_q + 8'd1;
        cyc_cnt_d = cyc_cnt_q;
        case (state_q)
            IDLE: begin
                dwell_d = 8'd0;
                state_d = (run || step) ? P1 : IDLE;
            end
            P1: if (expired) begin
                state_d = G1;
                dwell_d = 8'd0;
            end
            G1: if (expired) begin
                state_d = P2;
                dwell_d = 8'd0;
            end
            P2: if (expired) begin
                state_d = G2;
                dwell_d = 8'd0;
            end
            G2: if (expired) begin
                // step is deliberately ignored here: only run keeps the clock going
                state_d   = run ? P1 : IDLE;
                dwell_d   = 8'd0;
                cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
            end
            default: begin
                state_d = IDLE;
                dwell_d = 8'd0;
            end
        endcase
        phi1_d       = (state_d == P1);
        phi2_d       = (state_d == P2);
        phi1_start_d = (state_d == P1) && (state_q != P1);
        phi2_start_d = (state_d == P2) && (state_q != P2);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dwell_q      <= 8'd0;
            cyc_cnt_q    <= '0;
            phi1_q       <= 1'b0;
            phi2_q       <= 1'b0;
            phi1_start_q <= 1'b0;
            phi2_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            cyc_cnt_q    <= cyc_cnt_d;
            phi1_q       <= phi1_d;
            phi2_q       <= phi2_d;
            phi1_start_q <= phi1_start_d;
            phi2_start_q <= phi2_start_d;
            busy_q       <= busy_d;
        end
    end

    assign phi1       = phi1_q;
    assign phi2       = phi2_q;
    assign phi1_start = phi1_start_q;
    assign phi2_start = phi2_start_q;
    assign busy       = busy_q;
    assign cyc_cnt    = cyc_cnt_q;
endmodule
